// File: rtl/interrupt_request_arbiter_pkg.sv
// Shared definitions for the interrupt request arbiter: FSM state codes and
// default sizing shared with the downstream interrupt controller.
package interrupt_request_arbiter_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ASSERT  = 2'd1;
  localparam logic [1:0] SERVICE = 2'd2;

  localparam int IRQ_NUM_SRC_DEF = 8;
  localparam int IRQ_TIMER_W_DEF = 32;

  // The internal timer shares the request slot of the highest-numbered source.
  function automatic int timer_src_idx(input int num_src);
    return num_src - 1;
  endfunction

endpackage

// File: rtl/interrupt_request_arbiter_irq_sync_edge.sv
// One-bit three-flop synchroniser for an asynchronous request line; the last
// flop delays the synchronised level so a rising edge can be flagged.
module irq_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  logic sync_p0;
  logic sync_p1;
  logic sync_p2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
    end else begin
      sync_p0 <= async_in;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  assign rise = sync_p1 & ~sync_p2;

endmodule

// File: rtl/interrupt_request_arbiter.sv
// Collects, synchronises and latches interrupt edges, then issues one request pulse
// per serviced source. Define IRQ_TIMER_EN to add the periodic timer source.
module interrupt_request_arbiter
  import interrupt_request_arbiter_pkg::*;
#(
  parameter int NUM_SRC = IRQ_NUM_SRC_DEF,
  parameter int ID_W    = $clog2(NUM_SRC)
`ifdef IRQ_TIMER_EN
  ,
  parameter int TIMER_W = IRQ_TIMER_W_DEF
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               mask_wr,
  input  logic [NUM_SRC-1:0] mask_wdata,
  output logic [NUM_SRC-1:0] irq_mask,
  output logic [NUM_SRC-1:0] irq_pending,
  output logic               interrupt_signal,
  output logic [ID_W-1:0]    irq_id,
  input  logic               isr_done
`ifdef IRQ_TIMER_EN
  ,
  input  logic               timer_cmp_wr,
  input  logic [TIMER_W-1:0] timer_cmp_wdata
`endif
);

  function automatic logic [ID_W-1:0] lowest_set(input logic [NUM_SRC-1:0] v);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (v[i]) idx = ID_W'(i);
    end
    return idx;
  endfunction

  logic [NUM_SRC-1:0] rise_ext;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] clr;
  logic [ID_W-1:0]    winner;
  logic               take;
  logic [1:0]         state;

  // Input stage: per-source synchroniser and rising-edge detect
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
    irq_sync_edge u_sync (
      .clk      (clk),
      .reset    (reset),
      .async_in (irq_src[g]),
      .rise     (rise_ext[g])
    );
  end

`ifdef IRQ_TIMER_EN
  logic [TIMER_W-1:0] timer_cnt;
  logic [TIMER_W-1:0] timer_cmp;
  logic               timer_evt;

  assign timer_evt = (timer_cmp != '0) && (timer_cnt == timer_cmp);

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_cnt <= '0;
      timer_cmp <= '0;
    end else if (timer_cmp_wr) begin
      timer_cmp <= timer_cmp_wdata;
      timer_cnt <= '0;
    end else if ((timer_cmp == '0) || timer_evt) begin
      timer_cnt <= '0;
    end else begin
      timer_cnt <= timer_cnt + 1'b1;
    end
  end

  always_comb begin
    rise = rise_ext;
    rise[timer_src_idx(NUM_SRC)] = rise_ext[timer_src_idx(NUM_SRC)] | timer_evt;
  end
`else
  assign rise = rise_ext;
`endif

  // Selection stage: fixed priority, lowest enabled index wins
  assign eligible = irq_pending & irq_mask;
  assign winner   = lowest_set(eligible);
  assign take     = (state == IDLE) && (eligible != '0);
  assign clr      = take ? (NUM_SRC'(1) << winner) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_pending <= '0;
      irq_mask    <= '0;
    end else begin
      // A new edge in the same cycle as the clear keeps the bit set.
      irq_pending <= (irq_pending & ~clr) | rise;
      if (mask_wr) irq_mask <= mask_wdata;
    end
  end

  // Service stage: one request pulse, then hold until the ISR returns
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      irq_id <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            irq_id <= winner;
            state  <= ASSERT;
          end
        end
        ASSERT:  state <= SERVICE;
        SERVICE: if (isr_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign interrupt_signal = (state == ASSERT);

endmodule

// File: tb/tb_interrupt_request_arbiter.sv
// Self-checking bench for interrupt_request_arbiter: directed scenarios followed by
// random traffic, every cycle compared against a delay-line reference model.
module tb_interrupt_request_arbiter;

  localparam int NS   = 8;
  localparam int ID_W = 3;

  logic            clk;
  logic            reset;
  logic [NS-1:0]   irq_src;
  logic            mask_wr;
  logic [NS-1:0]   mask_wdata;
  logic [NS-1:0]   irq_mask;
  logic [NS-1:0]   irq_pending;
  logic            interrupt_signal;
  logic [ID_W-1:0] irq_id;
  logic            isr_done;
`ifdef IRQ_TIMER_EN
  logic            timer_cmp_wr;
  logic [31:0]     timer_cmp_wdata;
`endif

  interrupt_request_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .irq_src          (irq_src),
    .mask_wr          (mask_wr),
    .mask_wdata       (mask_wdata),
    .irq_mask         (irq_mask),
    .irq_pending      (irq_pending),
    .interrupt_signal (interrupt_signal),
    .irq_id           (irq_id),
    .isr_done         (isr_done)
`ifdef IRQ_TIMER_EN
    ,
    .timer_cmp_wr     (timer_cmp_wr),
    .timer_cmp_wdata  (timer_cmp_wdata)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: raw input history, pending/mask vectors, pulse/busy flags.
  logic [NS-1:0]   h0, h1, h2;
  logic [NS-1:0]   m_pend, m_mask;
  logic [ID_W-1:0] m_id;
  logic            m_pulse, m_busy;
`ifdef IRQ_TIMER_EN
  logic [31:0]     m_tcnt, m_tcmp;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [NS-1:0] rise;
    logic [NS-1:0] elig;
    @(posedge clk);
    // A level seen two samples ago that was low three samples ago is a new edge.
    rise = h1 & ~h2;
`ifdef IRQ_TIMER_EN
    if (m_tcmp != 0 && m_tcnt == m_tcmp) rise[NS-1] = 1'b1;
`endif
    if (reset) begin
      h0 = '0; h1 = '0; h2 = '0;
      m_pend = '0; m_mask = '0; m_id = '0;
      m_pulse = 1'b0; m_busy = 1'b0;
`ifdef IRQ_TIMER_EN
      m_tcnt = 0; m_tcmp = 0;
`endif
    end else begin
      elig = m_pend & m_mask;
      if (m_pulse) begin
        m_pulse = 1'b0;
      end else if (m_busy) begin
        if (isr_done) m_busy = 1'b0;
      end else if (elig != '0) begin
        for (int i = NS - 1; i >= 0; i--) if (elig[i]) m_id = ID_W'(i);
        m_pend[m_id] = 1'b0;
        m_pulse = 1'b1;
        m_busy  = 1'b1;
      end
      m_pend = m_pend | rise;
      if (mask_wr) m_mask = mask_wdata;
      h2 = h1; h1 = h0; h0 = irq_src;
`ifdef IRQ_TIMER_EN
      if (timer_cmp_wr) begin
        m_tcmp = timer_cmp_wdata; m_tcnt = 0;
      end else if (m_tcmp == 0 || m_tcnt == m_tcmp) m_tcnt = 0;
      else m_tcnt = m_tcnt + 1;
`endif
    end
    #1;
    chk("model_pending", 32'(irq_pending), 32'(m_pend));
    chk("model_mask", 32'(irq_mask), 32'(m_mask));
    chk("model_intsig", 32'(interrupt_signal), 32'(m_pulse));
    chk("model_id", 32'(irq_id), 32'(m_id));
  endtask

  task automatic pulse_src(input logic [NS-1:0] bits);
    irq_src = bits;
    step();
    irq_src = '0;
  endtask

  task automatic wait_pulse(input string tag, input int max_cycles, input int exp_id);
    int n;
    n = 0;
    while (interrupt_signal !== 1'b1 && n < max_cycles) begin
      step();
      n++;
    end
    chk({tag, "_seen"}, 32'(interrupt_signal), 32'd1);
    chk({tag, "_id"}, 32'(irq_id), 32'(exp_id));
  endtask

  // Called right after a pulse cycle: one cycle to reach SERVICE, then done.
  task automatic finish_isr();
    step();
    isr_done = 1'b1;
    step();
    isr_done = 1'b0;
  endtask

  task automatic write_mask(input logic [NS-1:0] m);
    mask_wr = 1'b1;
    mask_wdata = m;
    step();
    mask_wr = 1'b0;
  endtask

  initial begin
    int npulse;
    reset = 1'b1; irq_src = '0; mask_wr = 1'b0; mask_wdata = '0; isr_done = 1'b0;
    h0 = '0; h1 = '0; h2 = '0; m_pend = '0; m_mask = '0; m_id = '0;
    m_pulse = 1'b0; m_busy = 1'b0;
`ifdef IRQ_TIMER_EN
    timer_cmp_wr = 1'b0; timer_cmp_wdata = '0; m_tcnt = 0; m_tcmp = 0;
`endif
    step();
    step();
    chk("rst_pending", 32'(irq_pending), 32'd0);
    chk("rst_mask", 32'(irq_mask), 32'd0);
    chk("rst_intsig", 32'(interrupt_signal), 32'd0);
    chk("rst_id", 32'(irq_id), 32'd0);
    reset = 1'b0;

    // Single source latency: edge sampled at k, pending at k+2, pulse at k+3.
    write_mask(8'hFF);
    pulse_src(8'h08);
    step();
    step();
    chk("t1_pend_k2", 32'(irq_pending[3]), 32'd1);
    chk("t1_nopulse_k2", 32'(interrupt_signal), 32'd0);
    step();
    chk("t1_pulse_k3", 32'(interrupt_signal), 32'd1);
    chk("t1_id", 32'(irq_id), 32'd3);
    chk("t1_pend_clr", 32'(irq_pending[3]), 32'd0);
    step();
    chk("t1_pulse_end", 32'(interrupt_signal), 32'd0);
    isr_done = 1'b1;
    step();
    isr_done = 1'b0;

    // Two simultaneous edges: lower index first, the other after isr_done.
    pulse_src(8'h24);
    wait_pulse("t2_first", 6, 2);
    chk("t2_other_pend", 32'(irq_pending[5]), 32'd1);
    finish_isr();
    wait_pulse("t2_second", 4, 5);
    finish_isr();

    // Masked source keeps pending; unmasking makes it eligible the next cycle.
    write_mask(8'h00);
    pulse_src(8'h02);
    repeat (5) step();
    chk("t3_masked_pend", 32'(irq_pending[1]), 32'd1);
    chk("t3_masked_quiet", 32'(interrupt_signal), 32'd0);
    write_mask(8'h02);
    chk("t3_oldmask_quiet", 32'(interrupt_signal), 32'd0);
    step();
    chk("t3_unmask_pulse", 32'(interrupt_signal), 32'd1);
    chk("t3_unmask_id", 32'(irq_id), 32'd1);
    finish_isr();

    // New edge on the source being serviced waits for isr_done, then repeats.
    write_mask(8'hFF);
    pulse_src(8'h10);
    wait_pulse("t4_first", 6, 4);
    step();
    pulse_src(8'h10);
    repeat (4) step();
    chk("t4_repend", 32'(irq_pending[4]), 32'd1);
    chk("t4_held_off", 32'(interrupt_signal), 32'd0);
    isr_done = 1'b1;
    step();
    isr_done = 1'b0;
    wait_pulse("t4_again", 3, 4);
    finish_isr();
    isr_done = 1'b1;
    step();
    isr_done = 1'b0;
    step();
    chk("t4_spurious_quiet", 32'(interrupt_signal), 32'd0);
    chk("t4_spurious_pend", 32'(irq_pending), 32'd0);

    // Reset mid-service with two sources pending.
    pulse_src(8'h02);
    wait_pulse("t5_first", 6, 1);
    step();
    pulse_src(8'h0C);
    repeat (3) step();
    chk("t5_pend_before", 32'(irq_pending), 32'h0C);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5_pend", 32'(irq_pending), 32'd0);
    chk("t5_mask", 32'(irq_mask), 32'd0);
    chk("t5_intsig", 32'(interrupt_signal), 32'd0);
    chk("t5_id", 32'(irq_id), 32'd0);
    write_mask(8'hFF);
    pulse_src(8'h40);
    wait_pulse("t5_idle_after", 6, 6);
    finish_isr();

    // Random traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      reset      = ($urandom_range(0, 199) == 0);
      mask_wr    = ($urandom_range(0, 15) == 0);
      mask_wdata = NS'($urandom);
      isr_done   = ($urandom_range(0, 3) == 0);
      irq_src    = irq_src ^ NS'($urandom & $urandom & $urandom);
      step();
    end
    reset = 1'b0; mask_wr = 1'b0; isr_done = 1'b0; irq_src = '0;
    repeat (4) step();

`ifdef IRQ_TIMER_EN
    // Timer on the top source: one pulse every cmp+1 cycles, none when cmp is 0.
    begin
      int last;
      reset = 1'b1;
      step();
      reset = 1'b0;
      write_mask(8'h80);
      timer_cmp_wr = 1'b1;
      timer_cmp_wdata = 32'd10;
      step();
      timer_cmp_wr = 1'b0;
      isr_done = 1'b1;
      last = -1;
      npulse = 0;
      for (int c = 0; c < 70; c++) begin
        step();
        if (interrupt_signal === 1'b1) begin
          chk("t6_id", 32'(irq_id), 32'd7);
          if (last >= 0) chk("t6_period", 32'(c - last), 32'd11);
          last = c;
          npulse++;
        end
      end
      chk("t6_count", 32'(npulse >= 5), 32'd1);
      timer_cmp_wr = 1'b1;
      timer_cmp_wdata = 32'd0;
      step();
      timer_cmp_wr = 1'b0;
      repeat (5) step();
      npulse = 0;
      for (int c = 0; c < 40; c++) begin
        step();
        if (interrupt_signal === 1'b1) npulse++;
      end
      chk("t6_disabled", 32'(npulse), 32'd0);
      isr_done = 1'b0;
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
